counter_step_monitor: RTL and testbench

//  Downstream checker for the 4-bit up/down counter: samples counter value every clk, classifies

---
 rtl/counter_step_monitor.sv | 104 ++++++++++
 tb/tb_counter_step_monitor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/counter_step_monitor.sv
// counter_step_monitor: classifies counter steps, locks onto a clean stream, reports wraps/errors
module counter_step_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 3,
  parameter int ERR_LIMIT  = 2,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      counter_in,
  input  logic                  clear,
  output logic                  locked,
  output logic                  dir_down,
  output logic                  wrap_pulse,
  output logic                  wrap_dir,
  output logic                  step_err,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [WRAP_CNT_W-1:0] err_count
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(ERR_LIMIT + 1);
  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
  localparam logic [BW-1:0] ERR_V = BW'(ERR_LIMIT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] prev, delta;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [BW-1:0] bad_cnt, bad_nxt;
  logic is_up, is_dn, legal, is_jump, wrap, wrap_ev, err_ev;
  assign delta = counter_in - prev;
  assign is_up = delta == ONE;
  assign is_dn = &delta;
  assign legal = is_up | is_dn;
  assign is_jump = !legal && |delta;
  assign wrap = (is_up && &prev) || (is_dn && ~|prev);
  assign locked = state == LOCKED;
  always_comb begin
    state_nxt = state;
    good_nxt = good_cnt;
    bad_nxt = bad_cnt;
    wrap_ev = 1'b0;
    err_ev = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = ACQUIRE;
        good_nxt = '0;
        bad_nxt = '0;
      end
      ACQUIRE: begin
        if (legal) begin
          good_nxt = good_cnt + 1'b1;
          if (good_nxt == LOCK_V) begin
            state_nxt = LOCKED;
            bad_nxt = '0;
            wrap_ev = wrap;
          end
        end else if (is_jump) begin
          good_nxt = '0;
          err_ev = 1'b1;
        end
      end
      LOCKED: begin
        if (legal) begin
          bad_nxt = '0;
          wrap_ev = wrap;
        end else if (is_jump) begin
          err_ev = 1'b1;
          bad_nxt = bad_cnt + 1'b1;
          if (bad_nxt == ERR_V) begin
            state_nxt = ACQUIRE;
            good_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      prev <= '0;
      good_cnt <= '0;
      bad_cnt <= '0;
      dir_down <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_dir <= 1'b0;
      step_err <= 1'b0;
      wrap_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      prev <= counter_in;
      good_cnt <= good_nxt;
      bad_cnt <= bad_nxt;
      wrap_pulse <= wrap_ev;
      step_err <= err_ev;
      if (wrap_ev) wrap_dir <= is_dn;
      if (legal && state != IDLE) dir_down <= is_dn;
      wrap_count <= clear ? '0 : (wrap_ev && ~&wrap_count) ? wrap_count + 1'b1 : wrap_count;
      err_count <= clear ? '0 : (err_ev && ~&err_count) ? err_count + 1'b1 : err_count;
    end
  end
endmodule

// File: tb/tb_counter_step_monitor.sv
// tb_counter_step_monitor: directed checks of counter_step_monitor (default and 2-bit count instances)
module tb_counter_step_monitor;
  logic clk = 0, reset_n = 0, clear = 0;
  logic [3:0] counter_in = 0;
  logic locked, dir_down, wrap_pulse, wrap_dir, step_err;
  logic [7:0] wrap_count, err_count;
  logic locked2, dir_down2, wrap_pulse2, wrap_dir2, step_err2;
  logic [1:0] wrap_count2, err_count2;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  counter_step_monitor dut (
    .clk(clk), .reset_n(reset_n), .counter_in(counter_in), .clear(clear),
    .locked(locked), .dir_down(dir_down), .wrap_pulse(wrap_pulse), .wrap_dir(wrap_dir),
    .step_err(step_err), .wrap_count(wrap_count), .err_count(err_count)
  );

  counter_step_monitor #(.WRAP_CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .counter_in(counter_in), .clear(clear),
    .locked(locked2), .dir_down(dir_down2), .wrap_pulse(wrap_pulse2), .wrap_dir(wrap_dir2),
    .step_err(step_err2), .wrap_count(wrap_count2), .err_count(err_count2)
  );

  task automatic step(input logic [3:0] v);
    counter_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) step(4'(i * 5 + 3));
    n_checks++;
    if ({locked, dir_down, wrap_pulse, wrap_dir, step_err, wrap_count, err_count} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {locked, dir_down, wrap_pulse, wrap_dir, step_err, wrap_count, err_count});
    end
    reset_n = 1;
  endtask

  task automatic test_up_wrap;
    step(12);
    step(13);
    step(14);
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL up_prelock: got %b expected 0", locked); end
    step(15);
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL up_lock: got %b expected 1", locked); end
    step(0);
    n_checks++;
    if ({wrap_pulse, wrap_dir, dir_down} !== 3'b100) begin
      n_fail++; $display("FAIL up_wrap_flags: got %b expected 100", {wrap_pulse, wrap_dir, dir_down});
    end
    n_checks++;
    if (wrap_count !== 8'd1) begin n_fail++; $display("FAIL up_wrap_count: got %0d expected 1", wrap_count); end
    step(1);
    n_checks++;
    if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL up_wrap_oneshot: got %b expected 0", wrap_pulse); end
  endtask

  task automatic test_down_wrap;
    step(2);
    step(1);
    n_checks++;
    if ({dir_down, step_err, locked} !== 3'b101) begin
      n_fail++; $display("FAIL reversal: got %b expected 101", {dir_down, step_err, locked});
    end
    step(0);
    step(15);
    n_checks++;
    if ({wrap_pulse, wrap_dir, dir_down} !== 3'b111) begin
      n_fail++; $display("FAIL down_wrap_flags: got %b expected 111", {wrap_pulse, wrap_dir, dir_down});
    end
    n_checks++;
    if (wrap_count !== 8'd2) begin n_fail++; $display("FAIL down_wrap_count: got %0d expected 2", wrap_count); end
  endtask

  task automatic test_jump_relock;
    step(0);
    step(1);
    step(2);
    step(3);
    step(9);
    n_checks++;
    if ({step_err, locked} !== 2'b11 || err_count !== 8'd1) begin
      n_fail++; $display("FAIL jump1: got err=%b lock=%b cnt=%0d expected 1 1 1", step_err, locked, err_count);
    end
    step(14);
    n_checks++;
    if ({step_err, locked} !== 2'b10 || err_count !== 8'd2) begin
      n_fail++; $display("FAIL jump2: got err=%b lock=%b cnt=%0d expected 1 0 2", step_err, locked, err_count);
    end
    step(15);
    step(0);
    n_checks++;
    if ({wrap_pulse, step_err, locked} !== 3'b000 || wrap_count !== 8'd3) begin
      n_fail++; $display("FAIL acquire_wrap: got pulse=%b err=%b lock=%b cnt=%0d expected 0 0 0 3",
                         wrap_pulse, step_err, locked, wrap_count);
    end
    step(1);
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: got %b expected 1", locked); end
  endtask

  task automatic test_clear_wrap;
    step(0);
    clear = 1;
    step(15);
    clear = 0;
    n_checks++;
    if ({wrap_pulse, wrap_dir} !== 2'b11 || wrap_count !== 8'd0 || err_count !== 8'd0) begin
      n_fail++; $display("FAIL clear_wrap: got pulse=%b dir=%b wc=%0d ec=%0d expected 1 1 0 0",
                         wrap_pulse, wrap_dir, wrap_count, err_count);
    end
    step(14);
    n_checks++;
    if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL clear_hold: got %0d expected 0", wrap_count); end
  endtask

  task automatic test_saturate_reset;
    step(15);
    step(0);
    step(15);
    step(0);
    step(15);
    step(0);
    n_checks++;
    if (wrap_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_wrap2: got %0d expected 3", wrap_count2); end
    n_checks++;
    if (wrap_count !== 8'd5) begin n_fail++; $display("FAIL wrap8: got %0d expected 5", wrap_count); end
    reset_n = 0;
    #1;
    n_checks++;
    if ({wrap_count2, locked2, wrap_count, locked} !== 12'd0) begin
      n_fail++; $display("FAIL async_reset: got wc2=%0d l2=%b wc=%0d l=%b expected 0",
                         wrap_count2, locked2, wrap_count, locked);
    end
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic test_back_to_back;
    step(5);
    n_checks++;
    if (step_err !== 1'b0) begin n_fail++; $display("FAIL capture_only: got %b expected 0", step_err); end
    step(9);
    step(2);
    n_checks++;
    if (step_err !== 1'b1 || err_count !== 8'd2) begin
      n_fail++; $display("FAIL b2b_jumps: got err=%b cnt=%0d expected 1 2", step_err, err_count);
    end
    step(2);
    n_checks++;
    if (step_err !== 1'b0) begin n_fail++; $display("FAIL hold_no_err: got %b expected 0", step_err); end
    step(8);
    step(12);
    n_checks++;
    if (err_count2 !== 2'd3 || err_count !== 8'd4) begin
      n_fail++; $display("FAIL err_sat: got ec2=%0d ec=%0d expected 3 4", err_count2, err_count);
    end
  endtask

  initial begin
    test_reset;
    test_up_wrap;
    test_down_wrap;
    test_jump_relock;
    test_clear_wrap;
    test_saturate_reset;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
